// File: rtl/uart_autobaud.sv
`default_nettype none
// ============================================================================
// Module   : uart_autobaud
// Purpose  : Times the falling edges of a host sync character on RX to derive
//            the UART baud reload value, then confirms it via the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module uart_autobaud #(
  parameter logic [8:0]  SYNC     = 9'h055,
  parameter logic [12:0] BAUD_DEF = 13'd433,
  parameter int          IDLE_MIN = 1024,
  parameter int          MIN_CNT  = 64,
  parameter int          MAX_MISS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        rx_rdy,
  input  logic [8:0]  rx_data,
  input  logic        rearm,
  output logic [12:0] baud,
  output logic        locked,
  output logic        err
);

  localparam int c_idle_w = $clog2(IDLE_MIN + 1);
  localparam int c_miss_w = $clog2(MAX_MISS + 2);
  localparam logic [c_idle_w-1:0] c_idle_min = c_idle_w'(IDLE_MIN);
  localparam logic [c_miss_w-1:0] c_max_miss = c_miss_w'(MAX_MISS);
  localparam logic [15:0]         c_min_cnt  = 16'(MIN_CNT);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    ARMED     = 3'd1,
    MEASURE   = 3'd2,
    VERIFY    = 3'd3,
    LOCKED    = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_rx_meta;
  logic                r_rx_sync;
  logic                r_rx_prev;
  logic [c_idle_w-1:0] r_idle_cnt;
  logic [15:0]         r_meas_cnt;
  logic [1:0]          r_edge_cnt;
  logic [c_miss_w-1:0] r_miss_cnt;
  logic [12:0]         r_baud;
  logic                r_locked;
  logic                r_err;

  logic                w_fall;
  logic [16:0]         w_sum;
  logic [12:0]         w_baud_new;

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // Rounded N/8 - 1; the sum is kept 17 bits wide so N near 65535 cannot wrap.
  assign w_sum      = {1'b0, r_meas_cnt} + 17'd4;
  assign w_baud_new = 13'((w_sum >> 3) - 17'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_IDLE;
      r_idle_cnt <= '0;
      r_meas_cnt <= '0;
      r_edge_cnt <= '0;
      r_miss_cnt <= '0;
      r_baud     <= BAUD_DEF;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (!r_rx_sync)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != c_idle_min)
        r_idle_cnt <= r_idle_cnt + 1'b1;

      if (rearm) begin
        r_state    <= WAIT_IDLE;
        r_idle_cnt <= '0;
        r_meas_cnt <= '0;
        r_edge_cnt <= '0;
        r_miss_cnt <= '0;
        r_baud     <= BAUD_DEF;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          WAIT_IDLE: begin
            if (r_idle_cnt == c_idle_min)
              r_state <= ARMED;
          end

          ARMED: begin
            if (w_fall) begin
              r_meas_cnt <= 16'd1;
              r_edge_cnt <= 2'd0;
              r_state    <= MEASURE;
            end
          end

          MEASURE: begin
            r_meas_cnt <= r_meas_cnt + 16'd1;
            if (w_fall) begin
              r_edge_cnt <= r_edge_cnt + 2'd1;
              // Fourth edge seen here is the fifth edge of the character.
              if (r_edge_cnt == 2'd3) begin
                if (r_meas_cnt >= c_min_cnt) begin
                  r_baud     <= w_baud_new;
                  r_miss_cnt <= '0;
                  r_state    <= VERIFY;
                end else begin
                  r_err   <= 1'b1;
                  r_baud  <= BAUD_DEF;
                  r_state <= WAIT_IDLE;
                end
              end
            end else if (r_meas_cnt == 16'hFFFF) begin
              r_err   <= 1'b1;
              r_baud  <= BAUD_DEF;
              r_state <= WAIT_IDLE;
            end
          end

          VERIFY: begin
            if (rx_rdy) begin
              if (rx_data == SYNC) begin
                r_locked <= 1'b1;
                r_state  <= LOCKED;
              end else if (r_miss_cnt == c_max_miss) begin
                r_err   <= 1'b1;
                r_baud  <= BAUD_DEF;
                r_state <= WAIT_IDLE;
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end
          end

          LOCKED: begin
            r_locked <= 1'b1;
          end

          default: begin
            r_state  <= WAIT_IDLE;
            r_baud   <= BAUD_DEF;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign baud   = r_baud;
  assign locked = r_locked;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_autobaud
// Purpose  : Scoreboard bench: every change of {baud, locked, err} must match
//            the next expected event queued when the stimulus was driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_autobaud;

  localparam logic [8:0]  c_sync     = 9'h055;
  localparam logic [12:0] c_baud_def = 13'd433;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        rx_rdy;
  logic [8:0]  rx_data;
  logic        rearm;
  logic [12:0] baud;
  logic        locked;
  logic        err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [14:0] exp_q[$];
  logic [14:0] prev_obs;

  uart_autobaud #(
    .SYNC     (9'h055),
    .BAUD_DEF (13'd433),
    .IDLE_MIN (1024),
    .MIN_CNT  (64),
    .MAX_MISS (2)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .rearm   (rearm),
    .baud    (baud),
    .locked  (locked),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] ev(input logic [12:0] b, input logic l, input logic e);
    return {b, l, e};
  endfunction

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends start + 9 data bits (LSB first) + stop at p cycles per bit.
  // rearm5 pulses rearm on the cycle edge 5 reaches the state machine;
  // cut releases the line shortly after edge 5 to save time.
  task automatic send_frame(input int p, input logic [8:0] d, input bit rearm5, input bit cut);
    logic [10:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RX = bits[i];
      if (i == 8 && cut) begin
        repeat (16) @(negedge clk);
        RX = 1'b1;
        return;
      end
      if (i == 8 && rearm5) begin
        repeat (2) @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        repeat (p - 4) @(negedge clk);
      end else begin
        repeat (p - 1) @(negedge clk);
      end
    end
  endtask

  task automatic rdy(input logic [8:0] d);
    @(negedge clk);
    rx_data = d;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    rx_data = '0;
  endtask

  task automatic do_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  // Output monitor: pops one expected event per observed change.
  initial begin
    logic [14:0] cur;
    prev_obs = {c_baud_def, 2'b00};
    forever begin
      @(negedge clk);
      cur = {baud, locked, err};
      if (rst_n === 1'b1 && cur !== prev_obs) begin
        if (exp_q.size() == 0)
          check("spurious_output", 32'(cur), 32'(prev_obs));
        else
          check("scoreboard_event", 32'(cur), 32'(exp_q.pop_front()));
      end
      prev_obs = cur;
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0; RX = 1'b1; rx_rdy = 1'b0; rx_data = '0; rearm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_baud",   32'(baud),   32'(c_baud_def));
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    rst_n = 1'b1;

    // 115200: N = 3472 -> 433, lock one cycle after matching rx_rdy
    idle(1030);
    send_frame(434, c_sync, 1'b0, 1'b1);
    idle(40);
    check("baud_115200", 32'(baud), 32'd433);
    exp_q.push_back(ev(13'd433, 1'b1, 1'b0));
    rdy(c_sync);
    check("lock_115200", 32'(locked), 32'd1);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    do_rearm();
    check("unlock_115200", 32'(locked), 32'd0);
    check("pending_115200", 32'(exp_q.size()), 32'd0);

    // 9600: N = 41664 -> 5207, two garbage characters tolerated
    idle(1100);
    exp_q.push_back(ev(13'd5207, 1'b0, 1'b0));
    send_frame(5208, c_sync, 1'b0, 1'b1);
    idle(20);
    check("baud_9600", 32'(baud), 32'd5207);
    rdy(9'h0F0);
    rdy(9'h1AA);
    check("no_lock_on_garbage", 32'(locked), 32'd0);
    exp_q.push_back(ev(13'd5207, 1'b1, 1'b0));
    rdy(c_sync);
    check("lock_9600", 32'(locked), 32'd1);
    check("pending_9600", 32'(exp_q.size()), 32'd0);

    // rearm while locked at 5207, then relock at 115200
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    do_rearm();
    check("rearm_locked", 32'(locked), 32'd0);
    check("rearm_baud",   32'(baud),   32'd433);
    idle(1100);
    send_frame(434, c_sync, 1'b0, 1'b1);
    idle(40);
    exp_q.push_back(ev(13'd433, 1'b1, 1'b0));
    rdy(c_sync);
    check("relock", 32'(locked), 32'd1);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    do_rearm();
    check("pending_rearm", 32'(exp_q.size()), 32'd0);

    // too fast: N = 32 < 64
    idle(1100);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b1));
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    send_frame(4, c_sync, 1'b0, 1'b0);
    idle(20);
    check("pending_short", 32'(exp_q.size()), 32'd0);

    // RX stuck low after edge 1: err once meas_cnt reaches 65535
    idle(1100);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b1));
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    @(negedge clk);
    RX  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 70000; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'd65538);
    idle(10);
    check("pending_timeout", 32'(exp_q.size()), 32'd0);

    // three mismatches in VERIFY: err and default baud
    idle(1100);
    exp_q.push_back(ev(13'd299, 1'b0, 1'b0));
    send_frame(300, c_sync, 1'b0, 1'b0);
    check("baud_300", 32'(baud), 32'd299);
    rdy(9'h000);
    rdy(9'h0AA);
    check("miss2_no_err", 32'(err), 32'd0);
    check("miss2_baud",   32'(baud), 32'd299);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b1));
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    rdy(9'h155);
    check("miss3_err",  32'(err),  32'd1);
    check("miss3_baud", 32'(baud), 32'd433);
    idle(5);
    check("pending_miss", 32'(exp_q.size()), 32'd0);

    // reset pulsed mid-MEASURE; an early frame must not be measured
    idle(1100);
    @(negedge clk);
    RX = 1'b0;
    repeat (433) @(negedge clk);
    RX = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_baud",   32'(baud),   32'd433);
    check("midrst_locked", 32'(locked), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(500);
    send_frame(200, c_sync, 1'b0, 1'b0);
    idle(20);
    check("no_early_arm", 32'(baud), 32'd433);
    idle(1100);
    send_frame(434, c_sync, 1'b0, 1'b1);
    idle(40);
    exp_q.push_back(ev(13'd433, 1'b1, 1'b0));
    rdy(c_sync);
    check("lock_after_rst", 32'(locked), 32'd1);
    exp_q.push_back(ev(13'd433, 1'b0, 1'b0));
    do_rearm();
    check("pending_midrst", 32'(exp_q.size()), 32'd0);

    // rearm coincident with edge 5 wins: no baud load, no VERIFY
    idle(1100);
    send_frame(200, c_sync, 1'b1, 1'b0);
    idle(50);
    check("rearm_edge5_baud", 32'(baud), 32'd433);
    rdy(c_sync);
    idle(5);
    check("rearm_edge5_locked", 32'(locked), 32'd0);
    check("pending_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
